// File: rtl/branch_ctrl.sv
// Branch resolution, mispredict redirect/flush controller and PC-indexed BHT of 2-bit counters.
// Define BRANCH_CTRL_BHT_EN to build the BHT; otherwise prediction is static not-taken.
module branch_ctrl #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pc,
  output logic        pred_taken,
  input  logic        x_valid,
  input  logic [31:0] x_inst,
  input  logic [31:0] x_pc,
  input  logic        x_pred_taken,
  input  logic [31:0] x_target,
  input  logic        br_eq,
  input  logic        br_lt,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          next_redirect, next_flush;
  logic [31:0]   next_redirect_pc;
  logic [2:0]    funct3;
  logic          resolve, taken, mispredict;
  logic [31:0]   actual_pc;
  logic          unused_bits;

  assign funct3     = x_inst[14:12];
  assign resolve    = x_valid && (x_inst[6:0] == 7'b1100011) && (state == IDLE);
  assign mispredict = taken != x_pred_taken;
  assign actual_pc  = taken ? x_target : x_pc + 32'd4;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:          taken = br_eq;
      3'b001:          taken = !br_eq;
      3'b100, 3'b110:  taken = br_lt;
      3'b101, 3'b111:  taken = !br_lt;
      default:         taken = 1'b0;
    endcase
  end

  // Redirect is a single pulse; flush is stretched by the counter while in FLUSH.
  always_comb begin
    next_state       = state;
    next_cnt         = cnt;
    next_redirect    = 1'b0;
    next_flush       = 1'b0;
    next_redirect_pc = redirect_pc;
    case (state)
      IDLE: begin
        if (resolve && mispredict) begin
          next_state       = FLUSH;
          next_cnt         = CW'(FLUSH_CYCLES - 1);
          next_redirect    = 1'b1;
          next_flush       = 1'b1;
          next_redirect_pc = actual_pc;
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          next_state = IDLE;
        end else begin
          next_cnt   = cnt - CW'(1);
          next_flush = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      redirect    <= next_redirect;
      redirect_pc <= next_redirect_pc;
      flush       <= next_flush;
    end
  end

`ifdef BRANCH_CTRL_BHT_EN
  localparam int IW = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  logic [1:0]    bht [BHT_ENTRIES];
  logic [IW-1:0] f_idx, x_idx;

  assign f_idx       = f_pc[IW+1:2];
  assign x_idx       = x_pc[IW+1:2];
  // Read is pre-update by construction: no bypass from a same-cycle resolve.
  assign pred_taken  = bht[f_idx][1];
  assign unused_bits = ^{f_pc[31:IW+2], f_pc[1:0], x_inst[31:15], x_inst[11:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (resolve) begin
      if (taken && bht[x_idx] != 2'b11)
        bht[x_idx] <= bht[x_idx] + 2'b01;
      else if (!taken && bht[x_idx] != 2'b00)
        bht[x_idx] <= bht[x_idx] - 2'b01;
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign unused_bits = ^{f_pc, x_inst[31:15], x_inst[11:7]};
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios followed by random stimulus, checked against a
// cycle-level reference model (BHT expectations follow BRANCH_CTRL_BHT_EN).
module tb_branch_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int BHT_ENTRIES  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] f_pc = '0;
  logic        pred_taken;
  logic        x_valid = 1'b0;
  logic [31:0] x_inst = '0;
  logic [31:0] x_pc = '0;
  logic        x_pred_taken = 1'b0;
  logic [31:0] x_target = '0;
  logic        br_eq = 1'b0;
  logic        br_lt = 1'b0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining flush-high cycles, last redirect, counter values as plain ints.
  int          m_left = 0;
  logic        m_red = 1'b0;
  logic [31:0] m_rpc = '0;
  int          m_bht [BHT_ENTRIES];

  branch_ctrl #(.BHT_ENTRIES(BHT_ENTRIES), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .pred_taken(pred_taken),
    .x_valid(x_valid), .x_inst(x_inst), .x_pc(x_pc), .x_pred_taken(x_pred_taken),
    .x_target(x_target), .br_eq(br_eq), .br_lt(br_lt),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] br(input logic [2:0] f3);
    return {17'h0, f3, 5'h0, 7'b1100011};
  endfunction

  function automatic logic model_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic cond;
    if (f3 == 3'b010 || f3 == 3'b011) return 1'b0;
    cond = f3[2] ? lt : eq;
    return f3[0] ? !cond : cond;
  endfunction

  function automatic logic model_pred(input logic [31:0] pc);
`ifdef BRANCH_CTRL_BHT_EN
    return m_bht[int'(pc[5:2])] >= 2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic r, input logic v, input logic [31:0] inst, input logic [31:0] pc,
                           input logic pr, input logic [31:0] tgt, input logic eq, input logic lt);
    logic tk;
    int   idx;
    if (r) begin
      m_left = 0;
      m_red  = 1'b0;
      m_rpc  = '0;
      for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 1;
    end else if (m_left > 0) begin
      m_left--;
      m_red = 1'b0;
    end else begin
      m_red = 1'b0;
      if (v && inst[6:0] == 7'b1100011) begin
        tk  = model_taken(inst[14:12], eq, lt);
        idx = int'(pc[5:2]);
        if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        if (tk != pr) begin
          m_red  = 1'b1;
          m_rpc  = tk ? tgt : pc + 32'd4;
          m_left = FLUSH_CYCLES;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] inst, input logic [31:0] pc,
                               input logic pr, input logic [31:0] tgt, input logic eq, input logic lt,
                               input logic [31:0] fpc);
    @(negedge clk);
    rst = r; x_valid = v; x_inst = inst; x_pc = pc; x_pred_taken = pr;
    x_target = tgt; br_eq = eq; br_lt = lt; f_pc = fpc;
    #1;
    if (!r) checkOutput("pred_taken", {31'h0, pred_taken}, {31'h0, model_pred(fpc)});
    @(posedge clk);
    modelStep(r, v, inst, pc, pr, tgt, eq, lt);
    #1;
    checkOutput("redirect", {31'h0, redirect}, {31'h0, m_red});
    checkOutput("flush", {31'h0, flush}, {31'h0, logic'(m_left > 0)});
    if (m_red) checkOutput("redirect_pc", redirect_pc, m_rpc);
  endtask

  task automatic idleSteps(input int n, input logic [31:0] fpc);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, fpc);
  endtask

  initial begin
    logic [31:0] inst, pc;
    for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 1;

    // Reset state
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("reset_redirect_pc", redirect_pc, 32'h0);

    // BEQ taken, predicted not-taken
    applyStimulus(1'b0, 1'b1, br(3'b000), 32'h100, 1'b0, 32'h120, 1'b1, 1'b0, 32'h100);
    checkOutput("t1_redirect_pc", redirect_pc, 32'h120);
    idleSteps(3, 32'h100);

    // BNE not-taken, predicted taken
    applyStimulus(1'b0, 1'b1, br(3'b001), 32'h200, 1'b1, 32'h280, 1'b1, 1'b0, 32'h0);
    checkOutput("t2_redirect_pc", redirect_pc, 32'h204);
    idleSteps(2, 32'h200);

    // BLT training at 0x40, then aliasing through 0x80
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, br(3'b100), 32'h40, 1'b0, 32'h10, 1'b0, 1'b1, 32'h40);
    idleSteps(2, 32'h40);
    applyStimulus(1'b0, 1'b1, br(3'b100), 32'h40, 1'b1, 32'h10, 1'b0, 1'b1, 32'h40);
    idleSteps(1, 32'h40);
    applyStimulus(1'b0, 1'b1, br(3'b100), 32'h40, 1'b1, 32'h10, 1'b0, 1'b0, 32'h80);
    idleSteps(2, 32'h80);
    applyStimulus(1'b0, 1'b1, br(3'b100), 32'h40, 1'b0, 32'h10, 1'b0, 1'b0, 32'h40);
    idleSteps(1, 32'h80);

    // BGEU taken and correctly predicted
    applyStimulus(1'b0, 1'b1, br(3'b111), 32'h500, 1'b1, 32'h540, 1'b0, 1'b0, 32'h500);
    idleSteps(1, 32'h500);

    // Branch in X during flush is ignored; then reset during flush
    applyStimulus(1'b0, 1'b1, br(3'b000), 32'h300, 1'b0, 32'h340, 1'b1, 1'b0, 32'h300);
    applyStimulus(1'b0, 1'b1, br(3'b000), 32'h300, 1'b1, 32'h340, 1'b0, 1'b0, 32'h300);
    idleSteps(2, 32'h300);
    applyStimulus(1'b0, 1'b1, br(3'b000), 32'h300, 1'b0, 32'h340, 1'b1, 1'b0, 32'h300);
    applyStimulus(1'b1, 1'b1, br(3'b000), 32'h300, 1'b1, 32'h340, 1'b0, 1'b0, 32'h300);
    idleSteps(1, 32'h300);

    // Non-branch opcode, invalid funct3, PC wrap
    applyStimulus(1'b0, 1'b1, {17'h0, 3'b000, 5'h0, 7'b0110011}, 32'h600, 1'b1, 32'h640, 1'b1, 1'b0, 32'h600);
    applyStimulus(1'b0, 1'b1, br(3'b010), 32'h600, 1'b0, 32'h640, 1'b1, 1'b1, 32'h600);
    applyStimulus(1'b0, 1'b1, br(3'b010), 32'h600, 1'b1, 32'h640, 1'b1, 1'b1, 32'h600);
    checkOutput("t6_f3_010_pc", redirect_pc, 32'h604);
    idleSteps(2, 32'h600);
    applyStimulus(1'b0, 1'b1, br(3'b000), 32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_wrap_pc", redirect_pc, 32'h0);
    idleSteps(2, 32'h0);

    // Random traffic over a small PC range so counters alias and saturate
    for (int n = 0; n < 400; n++) begin
      inst = $urandom;
      inst[6:0] = ($urandom_range(0, 7) == 0) ? 7'b0110011 : 7'b1100011;
      pc = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      applyStimulus(1'b0 | ($urandom_range(0, 49) == 0), 1'($urandom), inst, pc, 1'($urandom),
                    $urandom, 1'($urandom), 1'($urandom), {24'h0, 6'($urandom_range(0, 63)), 2'b00});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
